mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares a single memory port between two requesters: port 0 (the cpu) and port 1 (a DMA/peripheral master).
- Each requester uses the cpu memory protocol: a one-cycle init strobe plus read_op, write_op, addr and wdata; the response is a ready pulse with rdata.
- A holding register captures each strobed request. One request at a time is issued downstream; round-robin arbitration applies on contention.
- Sits between the cpu/DMA and the memory/peripheral decoder.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, read/write data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
m0_init  in  1  port 0 request strobe, one cycle
m0_read_op  in  3  port 0 read op, 0 = no read
m0_write_op  in  2  port 0 write op, 0 = no write
m0_addr  in  ADDR_WIDTH  port 0 address
m0_wdata  in  DATA_WIDTH  port 0 write data
m0_ready  out  1  port 0 completion pulse
m1_init, m1_read_op, m1_write_op, m1_addr, m1_wdata, m1_ready  as port 0, for port 1
rdata  out  DATA_WIDTH  read data to both ports, valid only with the own ready
mem_init  out  1  downstream request strobe
mem_read_op  out  3  downstream read op
mem_write_op  out  2  downstream write op
mem_addr  out  ADDR_WIDTH  downstream address
mem_wdata  out  DATA_WIDTH  downstream write data
mem_rdata  in  DATA_WIDTH  downstream read data
mem_ready  in  1  downstream completion
busy  out  1  high in ISSUE or WAIT

Behaviour:
- Per-port state:
  - pending flag plus holding registers {read_op, write_op, addr, wdata}.
  - The holding registers load on mX_init when pending is clear, or when pending is being cleared that same cycle.
  - mX_init while pending stays set is ignored; the original request is retained.
- Arbiter FSM states: IDLE, ISSUE, WAIT. A last_grant bit and a grant register are kept.
- IDLE:
  - Candidates are (pendingX | mX_init).
  - One candidate: grant it. Two candidates: grant the port that is not last_grant.
  - When granting, go to ISSUE. For a direct init, load that port's fields into the holding register at the same edge.
- ISSUE:
  - mem_init = 1 for exactly one cycle.
  - mem_* fields are driven from the granted holding register.
  - Go to WAIT.
- WAIT:
  - mem_* fields are held stable; mem_init = 0.
  - On mem_ready: mX_ready = 1 combinationally for the granted port only; rdata = mem_rdata (combinational pass-through).
  - At that edge: clear pending[grant], set last_grant = grant, go to IDLE.
- Latency: init at cycle t into an idle arbiter gives mem_init at t+1. Minimum turnaround is mem_ready cycle, then IDLE, then ISSUE of the next request. For back-to-back contention, mem_init of the second request occurs 2 cycles after the first ready.
- In IDLE, mem_read_op, mem_write_op and mem_init are 0. mem_addr and mem_wdata are 0. m0_ready and m1_ready are 0.
- mem_ready outside WAIT is ignored and produces no mX_ready.
- Init from the granted port in the same cycle as its own ready: a new request is captured (set wins over clear).
- Init from the non-granted port during ISSUE/WAIT: latched as pending and served next.
- Reset (reset == 0) at any time, including mid-transaction:
  - state = IDLE, pending = 0, last_grant = 1 (so port 0 wins the first tie), holding registers = 0.
  - The in-flight request is abandoned and no ready is delivered.
  - All outputs are 0 in the cycle after the reset edge.
- Request kinds: read_op/write_op values are passed through unchanged. Requests with both ops 0 are still issued (the downstream handles them).

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding (IDLE/ISSUE/WAIT, 2 bits).
  - READ_OP_W = 3, WRITE_OP_W = 2, OP_NONE = 0.
- Sub-module mem_req_hold: pending flag, capture/clear logic and holding registers for one port. It is instantiated twice.
- Top: FSM, grant/last_grant and output muxing.

Test Plan:
- Single read, port 0: m0_init with read_op=3'd2, addr=0x100 at cycle 0 → mem_init at cycle 1 with addr 0x100. mem_ready at cycle 4 with mem_rdata=0xDEADBEEF → m0_ready=1 and rdata=0xDEADBEEF at cycle 4; m1_ready stays 0.
- Simultaneous init after reset: m0 write (addr=0x10, wdata=0x55) and m1 read (addr=0x20) at cycle 0 → port 0 served first. m1's mem_init occurs 2 cycles after m0's ready, with addr 0x20.
- Round-robin fairness: both ports re-init immediately upon their own ready, 6 times → grants alternate 0,1,0,1,0,1 and neither port starves.
- Stray and overrun: mem_ready pulse in IDLE → no mX_ready. A second m1_init while m1 is pending with addr=0x30 (original 0x20) → the issued addr is 0x20.
- Reset mid-WAIT: reset=0 for one cycle while port 1 is waiting → no m1_ready, busy=0, mem_init=0. A subsequent m1_init is served normally at the new address.
- Same-cycle re-init: m0_init asserted in the cycle m0_ready=1 → the new request is captured and issued. mem_init occurs 2 cycles later with the new addr.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and
// request-op field widths.
package mem_arb_pkg;

    localparam int READ_OP_W  = 3;
    localparam int WRITE_OP_W = 2;
    localparam int OP_NONE    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One memory-protocol link: request strobe/fields one way, ready/rdata back.
// The requester side uses master, the responder side uses slave.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  init;
    logic [READ_OP_W-1:0]  read_op;
    logic [WRITE_OP_W-1:0] write_op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (output init, read_op, write_op, addr, wdata,
                    input  rdata, ready);
    modport slave  (input  init, read_op, write_op, addr, wdata,
                    output rdata, ready);

endinterface

// File: rtl/mem_req_hold.sv
// Per-port request capture: pending flag plus holding registers for one
// strobed request.
module mem_req_hold
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [READ_OP_W-1:0]  read_op,
    input  logic [WRITE_OP_W-1:0] write_op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic                  pending,
    output logic [READ_OP_W-1:0]  hold_read_op,
    output logic [WRITE_OP_W-1:0] hold_write_op,
    output logic [ADDR_WIDTH-1:0] hold_addr,
    output logic [DATA_WIDTH-1:0] hold_wdata
);

    logic load;

    // A new strobe is accepted only when the slot is free or is being freed
    // this very cycle; a strobe into an occupied slot is dropped.
    assign load = init && (!pending || clr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending       <= 1'b0;
            hold_read_op  <= READ_OP_W'(OP_NONE);
            hold_write_op <= WRITE_OP_W'(OP_NONE);
            hold_addr     <= '0;
            hold_wdata    <= '0;
        end else if (load) begin
            pending       <= 1'b1;
            hold_read_op  <= read_op;
            hold_write_op <= write_op;
            hold_addr     <= addr;
            hold_wdata    <= wdata;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: captures strobed requests, issues one at a
// time downstream and round-robins between ports on contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master mem,
    output logic          busy
);

    state_t                state;
    logic                  grant;
    logic                  last_grant;
    logic                  done;
    logic [1:0]            pending;
    logic [1:0]            cand;
    logic [1:0]            clr;
    logic [READ_OP_W-1:0]  h_read_op  [2];
    logic [WRITE_OP_W-1:0] h_write_op [2];
    logic [ADDR_WIDTH-1:0] h_addr     [2];
    logic [DATA_WIDTH-1:0] h_wdata    [2];

    // Completion is suppressed while reset is asserted so an abandoned
    // transaction never reports ready.
    assign done = reset && (state == WAIT) && mem.ready;
    assign clr  = {done & grant, done & ~grant};
    assign cand = {pending[1] | m1.init, pending[0] | m0.init};

    mem_req_hold #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_hold0 (
        .clk(clk), .reset(reset), .init(m0.init), .read_op(m0.read_op),
        .write_op(m0.write_op), .addr(m0.addr), .wdata(m0.wdata), .clr(clr[0]),
        .pending(pending[0]), .hold_read_op(h_read_op[0]),
        .hold_write_op(h_write_op[0]), .hold_addr(h_addr[0]), .hold_wdata(h_wdata[0])
    );

    mem_req_hold #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_hold1 (
        .clk(clk), .reset(reset), .init(m1.init), .read_op(m1.read_op),
        .write_op(m1.write_op), .addr(m1.addr), .wdata(m1.wdata), .clr(clr[1]),
        .pending(pending[1]), .hold_read_op(h_read_op[1]),
        .hold_write_op(h_write_op[1]), .hold_addr(h_addr[1]), .hold_wdata(h_wdata[1])
    );

    // last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cand != 2'b00) begin
                        state <= ISSUE;
                        grant <= (cand == 2'b11) ? ~last_grant : cand[1];
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (mem.ready) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        mem.init     = (state == ISSUE);
        mem.read_op  = '0;
        mem.write_op = '0;
        mem.addr     = '0;
        mem.wdata    = '0;
        if (busy) begin
            mem.read_op  = h_read_op[grant];
            mem.write_op = h_write_op[grant];
            mem.addr     = h_addr[grant];
            mem.wdata    = h_wdata[grant];
        end
        m0.ready = clr[0];
        m1.ready = clr[1];
        m0.rdata = clr[0] ? mem.rdata : '0;
        m1.rdata = clr[1] ? mem.rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-latency stimulus with hand-computed
// expectations checked by immediate assertions.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .mem(mem_if), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_if.init = 0; m0_if.read_op = 0; m0_if.write_op = 0; m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.init = 0; m1_if.read_op = 0; m1_if.write_op = 0; m1_if.addr = 0; m1_if.wdata = 0;
        mem_if.ready = 0; mem_if.rdata = 0;
    endtask

    task automatic m0_req(input logic [2:0] rop, input logic [1:0] wop,
                          input logic [31:0] a, input logic [31:0] d);
        m0_if.init = 1; m0_if.read_op = rop; m0_if.write_op = wop; m0_if.addr = a; m0_if.wdata = d;
    endtask

    task automatic m1_req(input logic [2:0] rop, input logic [1:0] wop,
                          input logic [31:0] a, input logic [31:0] d);
        m1_if.init = 1; m1_if.read_op = rop; m1_if.write_op = wop; m1_if.addr = a; m1_if.wdata = d;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        logic [31:0] exp_addr;
        int          p;

        idle_inputs();
        reset = 0;
        tick();
        tick();
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_mem_init", mem_if.init, 0);
        chk("rst_mem_addr", mem_if.addr, 0);
        chk("rst_m0_ready", m0_if.ready, 0);
        chk("rst_m1_ready", m1_if.ready, 0);
        reset = 1;

        // single read from port 0
        m0_req(3'd2, 2'd0, 32'h100, 32'h0);
        settle();
        chk("t1_c0_mem_init", mem_if.init, 0);
        tick();
        idle_inputs();
        settle();
        chk("t1_c1_mem_init", mem_if.init, 1);
        chk("t1_c1_addr", mem_if.addr, 32'h100);
        chk("t1_c1_read_op", mem_if.read_op, 3'd2);
        chk("t1_c1_busy", busy, 1);
        tick();
        settle();
        chk("t1_c2_mem_init", mem_if.init, 0);
        chk("t1_c2_addr_held", mem_if.addr, 32'h100);
        tick();
        tick();
        mem_if.ready = 1; mem_if.rdata = 32'hDEADBEEF;
        settle();
        chk("t1_c4_m0_ready", m0_if.ready, 1);
        chk("t1_c4_rdata", m0_if.rdata, 32'hDEADBEEF);
        chk("t1_c4_m1_ready", m1_if.ready, 0);
        tick();
        idle_inputs();
        settle();
        chk("t1_c5_busy", busy, 0);
        chk("t1_c5_mem_addr", mem_if.addr, 0);
        chk("t1_c5_m0_ready", m0_if.ready, 0);

        // simultaneous init after reset: port 0 first, then port 1
        do_reset();
        m0_req(3'd0, 2'd1, 32'h10, 32'h55);
        m1_req(3'd1, 2'd0, 32'h20, 32'h0);
        tick();
        idle_inputs();
        settle();
        chk("t2_first_init", mem_if.init, 1);
        chk("t2_first_addr", mem_if.addr, 32'h10);
        chk("t2_first_wdata", mem_if.wdata, 32'h55);
        chk("t2_first_write_op", mem_if.write_op, 2'd1);
        tick();
        mem_if.ready = 1;
        settle();
        chk("t2_m0_ready", m0_if.ready, 1);
        chk("t2_m1_not_ready", m1_if.ready, 0);
        tick();
        idle_inputs();
        settle();
        chk("t2_gap_init", mem_if.init, 0);
        chk("t2_gap_busy", busy, 0);
        tick();
        settle();
        chk("t2_second_init", mem_if.init, 1);
        chk("t2_second_addr", mem_if.addr, 32'h20);
        chk("t2_second_read_op", mem_if.read_op, 3'd1);
        tick();
        mem_if.ready = 1; mem_if.rdata = 32'h1234;
        settle();
        chk("t2_m1_ready", m1_if.ready, 1);
        chk("t2_m1_rdata", m1_if.rdata, 32'h1234);
        chk("t2_m0_quiet", m0_if.ready, 0);
        chk("t2_m0_rdata_zero", m0_if.rdata, 0);
        tick();
        idle_inputs();

        // stray mem_ready in IDLE
        mem_if.ready = 1;
        settle();
        chk("stray_m0_ready", m0_if.ready, 0);
        chk("stray_m1_ready", m1_if.ready, 0);
        tick();
        idle_inputs();
        settle();
        chk("stray_busy", busy, 0);

        // overrun: second init while pending is ignored
        m1_req(3'd1, 2'd0, 32'h20, 32'h0);
        tick();
        m1_req(3'd1, 2'd0, 32'h30, 32'h0);
        settle();
        chk("ovr_issue_addr", mem_if.addr, 32'h20);
        tick();
        idle_inputs();
        settle();
        chk("ovr_wait_addr", mem_if.addr, 32'h20);
        mem_if.ready = 1;
        settle();
        chk("ovr_m1_ready", m1_if.ready, 1);
        tick();
        idle_inputs();
        settle();
        chk("ovr_no_pending", busy, 0);
        tick();
        settle();
        chk("ovr_no_reissue", mem_if.init, 0);

        // reset in the middle of WAIT
        m1_req(3'd1, 2'd0, 32'h40, 32'h0);
        tick();
        idle_inputs();
        tick();
        settle();
        chk("rmw_in_wait", busy, 1);
        reset = 0;
        tick();
        reset = 1;
        mem_if.ready = 1;
        settle();
        chk("rmw_m1_ready", m1_if.ready, 0);
        chk("rmw_busy", busy, 0);
        chk("rmw_mem_init", mem_if.init, 0);
        chk("rmw_mem_addr", mem_if.addr, 0);
        tick();
        idle_inputs();
        m1_req(3'd1, 2'd0, 32'h44, 32'h0);
        tick();
        idle_inputs();
        settle();
        chk("rmw_new_init", mem_if.init, 1);
        chk("rmw_new_addr", mem_if.addr, 32'h44);
        tick();
        mem_if.ready = 1;
        settle();
        chk("rmw_new_ready", m1_if.ready, 1);
        tick();
        idle_inputs();

        // same-cycle re-init on own ready
        m0_req(3'd1, 2'd0, 32'h200, 32'h0);
        tick();
        idle_inputs();
        tick();
        mem_if.ready = 1;
        m0_req(3'd2, 2'd0, 32'h300, 32'h0);
        settle();
        chk("sc_m0_ready", m0_if.ready, 1);
        tick();
        idle_inputs();
        settle();
        chk("sc_idle_init", mem_if.init, 0);
        tick();
        settle();
        chk("sc_new_init", mem_if.init, 1);
        chk("sc_new_addr", mem_if.addr, 32'h300);
        chk("sc_new_read_op", mem_if.read_op, 3'd2);
        tick();
        mem_if.ready = 1;
        settle();
        chk("sc_new_ready", m0_if.ready, 1);
        tick();
        idle_inputs();

        // round-robin: both ports re-request on each own ready
        do_reset();
        m0_req(3'd1, 2'd0, 32'h1000, 32'h0);
        m1_req(3'd1, 2'd0, 32'h2000, 32'h0);
        tick();
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            p = k % 2;
            exp_addr = (p == 0 ? 32'h1000 : 32'h2000) + 32'(k / 2);
            settle();
            chk($sformatf("rr%0d_init", k), mem_if.init, 1);
            chk($sformatf("rr%0d_addr", k), mem_if.addr, exp_addr);
            tick();
            mem_if.ready = 1;
            mem_if.rdata = 32'(k);
            if (p == 0) m0_req(3'd1, 2'd0, exp_addr + 1, 32'h0);
            else        m1_req(3'd1, 2'd0, exp_addr + 1, 32'h0);
            settle();
            chk($sformatf("rr%0d_m0_ready", k), m0_if.ready, (p == 0) ? 1'b1 : 1'b0);
            chk($sformatf("rr%0d_m1_ready", k), m1_if.ready, (p == 1) ? 1'b1 : 1'b0);
            tick();
            idle_inputs();
            tick();
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
